// File: rtl/srff_bank_sched.sv
// srff_bank_sched
// Round-robin scheduler that shares a bank of negedge-clocked SR flip-flops
// among several requesters. Each command is turned into a single one-cycle
// set or reset strobe, so the bank never sees S=R=1. The flop output is then
// read back and the command is acknowledged with a pass/fail flag.
//
// Ports:
//   i_clk      controller clock, rising edge (the bank samples on the falling edge)
//   i_reset    synchronous, active-low reset
//   i_req      per-requester command request (level)
//   i_req_op   per-requester op, slice i = [2i+1:2i]: 00 nop, 01 clear, 10 set, 11 toggle
//   i_req_idx  per-requester target flop index, slice i = [IDX_W*i +: IDX_W]
//   i_q_in     current Q of every bank flop
//   o_s_vec    set strobes to the bank, one-hot or zero
//   o_r_vec    reset strobes to the bank, one-hot or zero
//   o_ack      one-cycle completion pulse per requester
//   o_err      valid with o_ack; 1 = command failed
//   o_busy     high while a command is in flight
//   o_gnt_id   requester currently being served, valid while o_busy
module srff_bank_sched #(
  parameter int NUM_FF = 8,
  parameter int IDX_W  = 3,
  parameter int NREQ   = 4,
  parameter int GID_W  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NREQ-1:0]        i_req,
  input  logic [2*NREQ-1:0]      i_req_op,
  input  logic [IDX_W*NREQ-1:0]  i_req_idx,
  input  logic [NUM_FF-1:0]      i_q_in,
  output logic [NUM_FF-1:0]      o_s_vec,
  output logic [NUM_FF-1:0]      o_r_vec,
  output logic [NREQ-1:0]        o_ack,
  output logic                   o_err,
  output logic                   o_busy,
  output logic [GID_W-1:0]       o_gnt_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t              r_state;
  logic [GID_W-1:0]    r_ptr;
  logic [GID_W-1:0]    r_gntId;
  logic [IDX_W-1:0]    r_idx;
  logic                r_expected;
  logic [NUM_FF-1:0]   r_sVec;
  logic [NUM_FF-1:0]   r_rVec;
  logic [NREQ-1:0]     r_ack;
  logic                r_err;

  state_t              w_nextState;
  logic [GID_W-1:0]    w_nextPtr;
  logic [GID_W-1:0]    w_nextGnt;
  logic [IDX_W-1:0]    w_nextIdx;
  logic                w_nextExp;
  logic [NUM_FF-1:0]   w_nextS;
  logic [NUM_FF-1:0]   w_nextR;
  logic [NREQ-1:0]     w_nextAck;
  logic                w_nextErr;

  logic [NREQ-1:0]     w_elig;
  logic                w_found;
  logic [GID_W-1:0]    w_pick;
  logic [1:0]          w_pickOp;
  logic [IDX_W-1:0]    w_pickIdx;
  logic                w_pickExp;

  // Index decode is done by comparison against every legal position, so an
  // index beyond the bank never produces an out-of-range select.
  function automatic logic inRange(input logic [IDX_W-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FF; i++) begin
      if (idx == IDX_W'(i)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic qAt(input logic [IDX_W-1:0] idx,
                               input logic [NUM_FF-1:0] q);
    logic bitVal;
    bitVal = 1'b0;
    for (int i = 0; i < NUM_FF; i++) begin
      if (idx == IDX_W'(i)) bitVal = q[i];
    end
    return bitVal;
  endfunction

  function automatic logic [NUM_FF-1:0] oneHot(input logic [IDX_W-1:0] idx);
    logic [NUM_FF-1:0] vec;
    vec = '0;
    for (int i = 0; i < NUM_FF; i++) begin
      if (idx == IDX_W'(i)) vec[i] = 1'b1;
    end
    return vec;
  endfunction

  // A requester whose ack is showing this cycle still has its old command on
  // the bus, so it sits out one arbitration round.
  assign w_elig = i_req & ~r_ack;

  // Round-robin pick: first eligible requester at or above the pointer,
  // wrapping. Also resolves the value the target flop must end up holding;
  // toggle is fixed here against the current Q so it becomes a plain set or
  // clear.
  always_comb begin
    w_found   = 1'b0;
    w_pick    = '0;
    w_pickOp  = 2'b00;
    w_pickIdx = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && (j == (int'(r_ptr) + k) % NREQ) && w_elig[j]) begin
          w_found   = 1'b1;
          w_pick    = GID_W'(j);
          w_pickOp  = i_req_op[2*j +: 2];
          w_pickIdx = i_req_idx[IDX_W*j +: IDX_W];
        end
      end
    end
    case (w_pickOp)
      2'b10:   w_pickExp = 1'b1;
      2'b01:   w_pickExp = 1'b0;
      2'b11:   w_pickExp = ~qAt(w_pickIdx, i_q_in);
      default: w_pickExp = qAt(w_pickIdx, i_q_in);
    endcase
  end

  // Next-state and next-output logic. Strobes are only ever produced on the
  // way into DRIVE and default to zero everywhere else, which is what keeps
  // them one cycle long and mutually exclusive.
  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextGnt   = r_gntId;
    w_nextIdx   = r_idx;
    w_nextExp   = r_expected;
    w_nextS     = '0;
    w_nextR     = '0;
    w_nextAck   = '0;
    w_nextErr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextGnt = w_pick;
          w_nextIdx = w_pickIdx;
          w_nextExp = w_pickExp;
          w_nextPtr = GID_W'((int'(w_pick) + 1) % NREQ);
          if ((w_pickOp == 2'b00) || !inRange(w_pickIdx)) begin
            w_nextState = CHECK;
          end else begin
            w_nextState = DRIVE;
            if (w_pickExp) w_nextS = oneHot(w_pickIdx);
            else           w_nextR = oneHot(w_pickIdx);
          end
        end
      end
      DRIVE: begin
        w_nextState = CHECK;
      end
      CHECK: begin
        w_nextState = IDLE;
        for (int i = 0; i < NREQ; i++) begin
          if (r_gntId == GID_W'(i)) w_nextAck[i] = 1'b1;
        end
        w_nextErr = !inRange(r_idx) || (qAt(r_idx, i_q_in) != r_expected);
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Datapath registers. A reset in the middle of a command drops the strobes
  // and forgets the command without acknowledging it.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ptr      <= '0;
      r_gntId    <= '0;
      r_idx      <= '0;
      r_expected <= 1'b0;
      r_sVec     <= '0;
      r_rVec     <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ptr      <= w_nextPtr;
      r_gntId    <= w_nextGnt;
      r_idx      <= w_nextIdx;
      r_expected <= w_nextExp;
      r_sVec     <= w_nextS;
      r_rVec     <= w_nextR;
      r_ack      <= w_nextAck;
      r_err      <= w_nextErr;
    end
  end

  assign o_s_vec  = r_sVec;
  assign o_r_vec  = r_rVec;
  assign o_ack    = r_ack;
  assign o_err    = r_err;
  assign o_busy   = (r_state != IDLE);
  assign o_gnt_id = r_gntId;

endmodule

// File: tb/tb_srff_bank_sched.sv
// tb_srff_bank_sched
// Drives srff_bank_sched with a six-flop bank (so indices 6 and 7 are out of
// range) and a negedge behavioural SR bank model with per-flop stuck-at-0.
// Stimulus pushes hand-computed strobe and ack expectations, tagged with the
// cycle they must appear in; a monitor on the falling edge pops and compares.
module tb_srff_bank_sched;

  localparam int NUM_FF = 6;
  localparam int IDX_W  = 3;
  localparam int NREQ   = 4;
  localparam int GID_W  = 2;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TOG = 2'b11;

  typedef struct {
    logic [NUM_FF-1:0] s;
    logic [NUM_FF-1:0] r;
    int                at;
  } strobeExp_t;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic            err;
    int              at;
  } ackExp_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     reqOp;
  logic [IDX_W*NREQ-1:0] reqIdx;
  logic [NUM_FF-1:0]     bankQ = '0;
  logic [NUM_FF-1:0]     stuckMask;
  logic [NUM_FF-1:0]     sVec;
  logic [NUM_FF-1:0]     rVec;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic                  busy;
  logic [GID_W-1:0]      gntId;

  int cyc     = 0;
  int base    = 0;
  int nChecks = 0;
  int nFails  = 0;

  strobeExp_t strobeQ[$];
  ackExp_t    ackQ[$];

  srff_bank_sched #(
    .NUM_FF(NUM_FF),
    .IDX_W (IDX_W),
    .NREQ  (NREQ),
    .GID_W (GID_W)
  ) dut (
    .i_clk    (clock),
    .i_reset  (reset),
    .i_req    (req),
    .i_req_op (reqOp),
    .i_req_idx(reqIdx),
    .i_q_in   (bankQ),
    .o_s_vec  (sVec),
    .o_r_vec  (rVec),
    .o_ack    (ack),
    .o_err    (err),
    .o_busy   (busy),
    .o_gnt_id (gntId)
  );

  // Free-running clock and rising-edge cycle counter.
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Bank model: SR flops capturing on the falling edge; a stuck flop stays 0.
  always @(negedge clock) begin
    for (int i = 0; i < NUM_FF; i++) begin
      if (stuckMask[i])  bankQ[i] <= 1'b0;
      else if (sVec[i])  bankQ[i] <= 1'b1;
      else if (rVec[i])  bankQ[i] <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clock) begin
    strobeExp_t se;
    ackExp_t    ae;
    checkOutput("sr_overlap", 32'(sVec & rVec), 32'd0);
    if ((sVec | rVec) != '0) begin
      if (strobeQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_strobe: got s=%0h r=%0h at cycle %0d, want none", sVec, rVec, cyc);
      end else begin
        se = strobeQ.pop_front();
        checkOutput("s_vec", 32'(sVec), 32'(se.s));
        checkOutput("r_vec", 32'(rVec), 32'(se.r));
        checkOutput("strobe_cycle", 32'(cyc), 32'(se.at));
      end
    end
    if (ack != '0) begin
      if (ackQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_ack: got ack=%0h err=%0b at cycle %0d, want none", ack, err, cyc);
      end else begin
        ae = ackQ.pop_front();
        checkOutput("ack", 32'(ack), 32'(ae.ack));
        checkOutput("err", 32'(err), 32'(ae.err));
        checkOutput("ack_cycle", 32'(cyc), 32'(ae.at));
      end
    end else begin
      checkOutput("err_without_ack", 32'(err), 32'd0);
    end
  end

  task automatic setCmd(input int id, input logic [1:0] op, input logic [IDX_W-1:0] idx);
    reqOp[2*id +: 2]         = op;
    reqIdx[IDX_W*id +: IDX_W] = idx;
  endtask

  // Raise the request mask on a falling edge; expectations pushed right after
  // are timed relative to the cycle captured here.
  task automatic applyStimulus(input logic [NREQ-1:0] mask);
    @(negedge clock);
    base  = cyc;
    reset = 1'b1;
    req   = mask;
  endtask

  task automatic expectStrobe(input logic [NUM_FF-1:0] s, input logic [NUM_FF-1:0] r,
                              input int off);
    strobeQ.push_back('{s, r, base + off});
  endtask

  task automatic expectAck(input logic [NREQ-1:0] a, input logic e, input int off);
    ackQ.push_back('{a, e, base + off});
  endtask

  // Check the grant one cycle after issue, hold the request for 'hold'
  // cycles in total, then drop it and let the DUT drain.
  task automatic finishCmd(input int hold, input logic [GID_W-1:0] expGnt);
    @(negedge clock);
    checkOutput("gnt_id", 32'(gntId), 32'(expGnt));
    checkOutput("busy", 32'(busy), 32'd1);
    repeat (hold - 1) @(negedge clock);
    req = '0;
    repeat (4) @(negedge clock);
  endtask

  // Hard stop in case something never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    req       = 4'b1111;
    reqOp     = '0;
    reqIdx    = '0;
    stuckMask = '0;
    setCmd(0, OP_SET, 3'd0);
    setCmd(1, OP_SET, 3'd1);
    setCmd(2, OP_SET, 3'd2);
    setCmd(3, OP_SET, 3'd3);

    // Reset held with every request high: nothing may come out.
    repeat (2) @(negedge clock);
    checkOutput("reset_s_vec", 32'(sVec), 32'd0);
    checkOutput("reset_r_vec", 32'(rVec), 32'd0);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_gnt_id", 32'(gntId), 32'd0);

    // Release reset: requester 0 wins first, sets flop 0.
    $display("[TB] reset release, first grant");
    applyStimulus(4'b1111);
    expectStrobe(6'h01, 6'h00, 1);
    expectAck(4'b0001, 1'b0, 3);
    finishCmd(1, 2'd0);

    // Requester 1 sets flop 5 (currently 0).
    $display("[TB] single set");
    setCmd(1, OP_SET, 3'd5);
    applyStimulus(4'b0010);
    expectStrobe(6'h20, 6'h00, 1);
    expectAck(4'b0010, 1'b0, 3);
    finishCmd(1, 2'd1);

    // Requester 3: set flop 2, then toggle twice (1->0 via reset, 0->1 via set).
    $display("[TB] toggle sequence");
    setCmd(3, OP_SET, 3'd2);
    applyStimulus(4'b1000);
    expectStrobe(6'h04, 6'h00, 1);
    expectAck(4'b1000, 1'b0, 3);
    finishCmd(1, 2'd3);
    setCmd(3, OP_TOG, 3'd2);
    applyStimulus(4'b1000);
    expectStrobe(6'h00, 6'h04, 1);
    expectAck(4'b1000, 1'b0, 3);
    finishCmd(1, 2'd3);
    applyStimulus(4'b1000);
    expectStrobe(6'h04, 6'h00, 1);
    expectAck(4'b1000, 1'b0, 3);
    finishCmd(1, 2'd3);

    // Three requesters holding clears: service order 0,1,3,0, three cycles apart.
    $display("[TB] round robin");
    setCmd(0, OP_CLR, 3'd0);
    setCmd(1, OP_CLR, 3'd1);
    setCmd(3, OP_CLR, 3'd4);
    applyStimulus(4'b1011);
    expectStrobe(6'h00, 6'h01, 1);
    expectStrobe(6'h00, 6'h02, 4);
    expectStrobe(6'h00, 6'h10, 7);
    expectStrobe(6'h00, 6'h01, 10);
    expectAck(4'b0001, 1'b0, 3);
    expectAck(4'b0010, 1'b0, 6);
    expectAck(4'b1000, 1'b0, 9);
    expectAck(4'b0001, 1'b0, 12);
    finishCmd(12, 2'd0);

    // Failure paths: stuck flop, out-of-range indices, and a passing nop.
    $display("[TB] error cases");
    stuckMask = 6'b001000;
    setCmd(2, OP_SET, 3'd3);
    applyStimulus(4'b0100);
    expectStrobe(6'h08, 6'h00, 1);
    expectAck(4'b0100, 1'b1, 3);
    finishCmd(1, 2'd2);
    setCmd(3, OP_SET, 3'd7);
    applyStimulus(4'b1000);
    expectAck(4'b1000, 1'b1, 2);
    finishCmd(1, 2'd3);
    setCmd(0, OP_SET, 3'd6);
    applyStimulus(4'b0001);
    expectAck(4'b0001, 1'b1, 2);
    finishCmd(1, 2'd0);
    setCmd(1, OP_NOP, 3'd5);
    applyStimulus(4'b0010);
    expectAck(4'b0010, 1'b0, 2);
    finishCmd(1, 2'd1);
    stuckMask = '0;

    // Reset during DRIVE: strobe seen once, no ack, pointer back to 0.
    $display("[TB] reset during drive");
    setCmd(1, OP_SET, 3'd1);
    applyStimulus(4'b0010);
    expectStrobe(6'h02, 6'h00, 1);
    @(negedge clock);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    req   = '0;
    @(negedge clock);
    checkOutput("abort_s_vec", 32'(sVec), 32'd0);
    checkOutput("abort_r_vec", 32'(rVec), 32'd0);
    checkOutput("abort_ack", 32'(ack), 32'd0);
    checkOutput("abort_busy_after", 32'(busy), 32'd0);

    // With pointer at 0, requester 1 beats requester 3.
    setCmd(1, OP_SET, 3'd1);
    setCmd(3, OP_SET, 3'd0);
    applyStimulus(4'b1010);
    expectStrobe(6'h02, 6'h00, 1);
    expectAck(4'b0010, 1'b0, 3);
    finishCmd(1, 2'd1);

    repeat (2) @(negedge clock);
    checkOutput("strobe_queue_empty", 32'(strobeQ.size()), 32'd0);
    checkOutput("ack_queue_empty", 32'(ackQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/srff_bank_sched.md
Name: srff_bank_sched

Overview:
Scheduler that shares a bank of negedge-clocked SR flip-flops (sync active-low reset, S=R=1 undefined) among several requesters. Each requester issues set / clear / toggle / nop commands against one flop index. The block arbitrates round-robin and drives a one-cycle s/r pulse to the bank. It guarantees S=R=1 never reaches any flop, reads back the flop output and acknowledges each command with a pass/fail flag. It sits between the control clients and the flop bank.

Parameters:
NUM_FF, 8, number of SR flops in the bank
IDX_W, 3, width of a flop index
NREQ, 4, number of requesters
GID_W, 2, width of the grant id (clog2 of NREQ)

Ports:
clk  in  1  controller clock; rising edge (bank samples on falling edge)
reset  in  1  synchronous, active-low reset
req  in  NREQ  per-requester command request, level
req_op  in  2*NREQ  per-requester op; slice i = bits [2i+1:2i]: 00 nop, 01 clear, 10 set, 11 toggle
req_idx  in  IDX_W*NREQ  per-requester target flop index, slice i
q_in  in  NUM_FF  current Q of each bank flop
s_vec  out  NUM_FF  set strobes to bank, one-hot or zero
r_vec  out  NUM_FF  reset strobes to bank, one-hot or zero
ack  out  NREQ  one-cycle completion pulse per requester
err  out  1  valid with ack; 1 = command failed
busy  out  1  high while not IDLE
gnt_id  out  GID_W  requester currently being served; valid while busy

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE; s_vec=0, r_vec=0, ack=0, err=0, gnt_id=0; rr pointer=0.
  - A reset mid-command abandons that command: no ack, strobes drop at the same edge.
- FSM has three states: IDLE, DRIVE, CHECK.
- IDLE:
  - If any eligible req is high, pick the first high req at or above ptr, wrapping modulo NREQ.
  - Latch gnt_id, op, idx and expected value: set→1, clear→0, toggle→~q_in[idx] sampled now, nop→q_in[idx].
  - Set ptr=(gnt+1) mod NREQ.
  - Next state is DRIVE, except when idx≥NUM_FF or op=nop: skip DRIVE, go directly to CHECK, keep s_vec/r_vec at 0.
- DRIVE (exactly one cycle):
  - set or toggle-to-1: s_vec[idx]=1, r_vec=0.
  - clear or toggle-to-0: r_vec[idx]=1, s_vec=0.
  - The bank falling edge inside this cycle captures the strobe. Next state is CHECK with strobes cleared at the exiting edge.
- CHECK (one cycle):
  - err_next = (idx≥NUM_FF) | (q_in[idx] != expected).
  - Next state is IDLE; at that edge ack[gnt_id]=1 and err=err_next, both for one cycle.
- Latency: req sampled at edge E0 → DRIVE after E0 → CHECK after E1 → ack/err high from E2 to E3. One command per 3 cycles; nop and out-of-range take 2 cycles.
- Requester contract:
  - op/idx must be stable while req is high, until ack.
  - A requester may hold req high to issue back-to-back commands.
  - In the IDLE cycle where ack[i]=1, requester i is not eligible. This prevents a double issue of a stale command.
- Invariants:
  - (s_vec & r_vec)==0 always.
  - popcount(s_vec|r_vec)≤1.
  - Strobes are zero outside DRIVE.
  - ack is one-hot or zero; err=0 whenever ack=0.
- req deasserted after grant: the command still completes and is acked.
- Toggle resolves to set or clear only, so the bank never receives S=R=1.

Test Plan:
1. reset=0 for 2 cycles with req=4'b1111 → s_vec=r_vec=0, ack=0, busy=0. Release reset → first grant is gnt_id=0.
2. Requester 1: set on idx 5, q_in[5]=0, bank model updating on negedge → s_vec=8'h20 for exactly one cycle, then ack=4'b0010 with err=0 three cycles after req.
3. req=4'b1011, all holding clear on distinct idx → grants in order 0,1,3,0,… Each ack is one-hot; no requester is granted twice in a row while others wait.
4. Toggle idx 2 with q_in[2]=1 → r_vec=8'h04, s_vec=0. A second toggle gives s_vec=8'h04. Never s_vec&r_vec≠0.
5. Set idx 3 with the bank model stuck at 0 → ack with err=1. Idx 3'd7 with NUM_FF=6 → no strobe, ack after 2 cycles with err=1.
6. Assert reset=0 during DRIVE → strobes 0 at that edge, no ack for the aborted command, ptr=0 after release.
